// File: rtl/hs_byte_serializer.sv
// HS transmit byte serializer: frames each burst as HS-zero, sync, payload and trail,
// then splits every byte into even/odd bit pairs for the DDR output stage.
// Optional build macro HS_BYTE_CNT_EN adds the HsByteCnt payload byte counter output.
module hs_byte_serializer #(
    parameter int unsigned HS_ZERO_BYTES = 4,
    parameter int unsigned TRAIL_BYTES   = 2,
    parameter logic [7:0]  SYNC_BYTE     = 8'hB8
) (
    input  logic        TxDDRClkHS,
    input  logic        TxRst_n,
    input  logic        TxRequestHS,
    input  logic [7:0]  TxDataHS,
    output logic        TxReadyHS,
`ifdef HS_BYTE_CNT_EN
    output logic [15:0] HsByteCnt,
`endif
    output logic        serial_B1,
    output logic        serial_B2,
    output logic        deff_en,
    output logic        TxHSActive
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ZERO  = 3'd1,
        ST_SYNC  = 3'd2,
        ST_DATA  = 3'd3,
        ST_TRAIL = 3'd4
    } state_t;

    localparam logic [7:0] ZERO_LAST  = 8'(HS_ZERO_BYTES - 1);
    localparam logic [7:0] TRAIL_LAST = 8'(TRAIL_BYTES - 1);

    state_t     state_r;
    logic [1:0] phase_r;
    logic [7:0] slot_cnt_r;
    logic [7:0] byte_r;
    logic       last_bit_r;

    // Bit pair {odd, even} of byte b presented in phase p (LSB-first).
    function automatic logic [1:0] pair_of(input logic [7:0] b, input logic [1:0] p);
        case (p)
            2'd0:    return {b[1], b[0]};
            2'd1:    return {b[3], b[2]};
            2'd2:    return {b[5], b[4]};
            2'd3:    return {b[7], b[6]};
            default: return 2'b00;
        endcase
    endfunction

    // Accept strobe: last phase of a sync/data slot while the PPI still requests.
    always_comb begin
        TxReadyHS = 1'b0;
        if (((state_r == ST_SYNC) || (state_r == ST_DATA)) && (phase_r == 2'd3)) begin
            TxReadyHS = TxRequestHS;
        end else begin
            TxReadyHS = 1'b0;
        end
    end

    // Burst FSM; each output is loaded with the value of the slot/phase being entered.
    always_ff @(posedge TxDDRClkHS or negedge TxRst_n) begin
        if (!TxRst_n) begin
            state_r    <= ST_IDLE;
            phase_r    <= 2'd0;
            slot_cnt_r <= 8'd0;
            byte_r     <= 8'd0;
            last_bit_r <= 1'b0;
            serial_B1  <= 1'b0;
            serial_B2  <= 1'b0;
            deff_en    <= 1'b0;
            TxHSActive <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    phase_r    <= 2'd0;
                    slot_cnt_r <= 8'd0;
                    {serial_B2, serial_B1} <= 2'b00;
                    if (TxRequestHS) begin
                        state_r    <= ST_ZERO;
                        deff_en    <= 1'b1;
                        TxHSActive <= 1'b1;
                    end else begin
                        deff_en    <= 1'b0;
                        TxHSActive <= 1'b0;
                    end
                end
                ST_ZERO: begin
                    phase_r <= phase_r + 2'd1;
                    if ((phase_r == 2'd3) && (slot_cnt_r == ZERO_LAST)) begin
                        state_r    <= ST_SYNC;
                        slot_cnt_r <= 8'd0;
                        {serial_B2, serial_B1} <= pair_of(SYNC_BYTE, 2'd0);
                    end else if (phase_r == 2'd3) begin
                        slot_cnt_r <= slot_cnt_r + 8'd1;
                        {serial_B2, serial_B1} <= 2'b00;
                    end else begin
                        {serial_B2, serial_B1} <= 2'b00;
                    end
                end
                ST_SYNC, ST_DATA: begin
                    phase_r <= phase_r + 2'd1;
                    if ((phase_r == 2'd3) && TxRequestHS) begin
                        state_r <= ST_DATA;
                        byte_r  <= TxDataHS;
                        {serial_B2, serial_B1} <= pair_of(TxDataHS, 2'd0);
                    end else if (phase_r == 2'd3) begin
                        // Trail idles at the inverse of the final transmitted bit.
                        state_r    <= ST_TRAIL;
                        slot_cnt_r <= 8'd0;
                        if (state_r == ST_SYNC) begin
                            last_bit_r <= SYNC_BYTE[7];
                            {serial_B2, serial_B1} <= {~SYNC_BYTE[7], ~SYNC_BYTE[7]};
                        end else begin
                            last_bit_r <= byte_r[7];
                            {serial_B2, serial_B1} <= {~byte_r[7], ~byte_r[7]};
                        end
                    end else if (state_r == ST_SYNC) begin
                        {serial_B2, serial_B1} <= pair_of(SYNC_BYTE, phase_r + 2'd1);
                    end else begin
                        {serial_B2, serial_B1} <= pair_of(byte_r, phase_r + 2'd1);
                    end
                end
                ST_TRAIL: begin
                    phase_r <= phase_r + 2'd1;
                    if ((phase_r == 2'd3) && (slot_cnt_r == TRAIL_LAST)) begin
                        state_r    <= ST_IDLE;
                        slot_cnt_r <= 8'd0;
                        deff_en    <= 1'b0;
                        TxHSActive <= 1'b0;
                        {serial_B2, serial_B1} <= 2'b00;
                    end else if (phase_r == 2'd3) begin
                        slot_cnt_r <= slot_cnt_r + 8'd1;
                        {serial_B2, serial_B1} <= {~last_bit_r, ~last_bit_r};
                    end else begin
                        {serial_B2, serial_B1} <= {~last_bit_r, ~last_bit_r};
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    phase_r    <= 2'd0;
                    slot_cnt_r <= 8'd0;
                    deff_en    <= 1'b0;
                    TxHSActive <= 1'b0;
                    {serial_B2, serial_B1} <= 2'b00;
                end
            endcase
        end
    end

`ifdef HS_BYTE_CNT_EN
    // Payload byte counter: restarts on sync entry, saturates, holds after the burst.
    always_ff @(posedge TxDDRClkHS or negedge TxRst_n) begin
        if (!TxRst_n) begin
            HsByteCnt <= 16'd0;
        end else if ((state_r == ST_ZERO) && (phase_r == 2'd3) && (slot_cnt_r == ZERO_LAST)) begin
            HsByteCnt <= 16'd0;
        end else if (TxReadyHS && (HsByteCnt != 16'hFFFF)) begin
            HsByteCnt <= HsByteCnt + 16'd1;
        end else begin
            HsByteCnt <= HsByteCnt;
        end
    end
`endif

endmodule

// File: tb/tb_hs_byte_serializer.sv
// Self-checking bench for hs_byte_serializer: per-cycle expected output words are
// generated from a burst-level stream model, queued when driven, popped when sampled.
module tb_hs_byte_serializer;

    localparam int ZB = 4;
    localparam int TB = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic [7:0]  data = 8'd0;
    logic        ready, b1, b2, en, act;
`ifdef HS_BYTE_CNT_EN
    logic [15:0] cnt;
`endif

    int errors = 0;
    int checks = 0;
    logic [4:0] exp_q[$];
    logic [7:0] burst_bytes[$];

    always #5 clk = ~clk;

    hs_byte_serializer #(
        .HS_ZERO_BYTES(ZB),
        .TRAIL_BYTES  (TB),
        .SYNC_BYTE    (8'hB8)
    ) dut (
        .TxDDRClkHS (clk),
        .TxRst_n    (rst_n),
        .TxRequestHS(req),
        .TxDataHS   (data),
        .TxReadyHS  (ready),
`ifdef HS_BYTE_CNT_EN
        .HsByteCnt  (cnt),
`endif
        .serial_B1  (b1),
        .serial_B2  (b2),
        .deff_en    (en),
        .TxHSActive (act)
    );

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Runs one burst of burst_bytes; hold keeps the request high through the trail,
    // abort_at pulls reset in that cycle (-1 = never).
    task automatic run_burst(input string name, input bit hold, input int abort_at);
        int n, sync_start, data_start, trail_start, idle_at, last_c, k, p;
        logic [7:0] sb, cur, sh;
        logic last_bit, r, rdy;
        logic [4:0] e;
        sb          = 8'hB8;
        n           = burst_bytes.size();
        sync_start  = 1 + 4 * ZB;
        data_start  = sync_start + 4;
        trail_start = data_start + 4 * n;
        idle_at     = trail_start + 4 * TB;
        last_c      = hold ? idle_at - 1 : idle_at + 1;
        last_bit    = (n == 0) ? sb[7] : burst_bytes[n-1][7];
        for (int c = 0; c <= last_c; c++) begin
            @(posedge clk);
            #1;
            r = (c == 0) || ((n > 0) && (c <= data_start - 1 + 4 * (n - 1))) ||
                (hold && (c >= trail_start));
            rdy = (n > 0) && (c >= data_start - 1) && (c <= data_start - 1 + 4 * (n - 1)) &&
                  (((c - data_start + 1) % 4) == 0);
            req  = r;
            data = rdy ? burst_bytes[(c - data_start + 1) / 4] : 8'($urandom);
            if ((c == 0) || (c >= idle_at)) begin
                e = 5'b00000;
            end else if (c < sync_start) begin
                e = 5'b01100;
            end else if (c < data_start) begin
                sh = sb >> (2 * (c - sync_start));
                e  = {rdy, 1'b1, 1'b1, sh[1], sh[0]};
            end else if (c < trail_start) begin
                k   = (c - data_start) / 4;
                p   = (c - data_start) % 4;
                cur = burst_bytes[k];
                sh  = cur >> (2 * p);
                e   = {rdy, 1'b1, 1'b1, sh[1], sh[0]};
            end else begin
                e = {1'b0, 1'b1, 1'b1, ~last_bit, ~last_bit};
            end
            exp_q.push_back(e);
            #1;
            check_val($sformatf("%s c%0d {rdy,en,act,b2,b1}", name, c),
                      {11'd0, ready, en, act, b2, b1}, {11'd0, exp_q.pop_front()});
`ifdef HS_BYTE_CNT_EN
            if (c == sync_start) check_val($sformatf("%s cnt_at_sync", name), cnt, 16'd0);
`endif
            if (c == abort_at) begin
                #1 rst_n = 1'b0;
                #1 check_val($sformatf("%s reset_outputs", name),
                             {11'd0, ready, en, act, b2, b1}, 16'd0);
`ifdef HS_BYTE_CNT_EN
                check_val($sformatf("%s reset_cnt", name), cnt, 16'd0);
`endif
                req = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
        end
`ifdef HS_BYTE_CNT_EN
        check_val($sformatf("%s cnt_end", name), cnt, 16'(n));
`endif
        if (!hold) req = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("reset_state", {11'd0, ready, en, act, b2, b1}, 16'd0);
        rst_n = 1'b1;

        burst_bytes = '{8'h5A, 8'hC3};
        run_burst("two_bytes", 1'b0, -1);

        burst_bytes = {};
        run_burst("req_pulse", 1'b0, -1);

        burst_bytes = {};
        for (int i = 0; i < 20; i++) burst_bytes.push_back(8'(i));
        run_burst("burst20", 1'b0, -1);

        // Abort in phase 2 of the first payload byte, then restart from HS-zero.
        burst_bytes = '{8'hA5, 8'h3C, 8'h7E};
        run_burst("abort", 1'b0, 1 + 4 * ZB + 4 + 2);
        burst_bytes = '{8'h96};
        run_burst("after_reset", 1'b0, -1);

        burst_bytes = '{8'h81};
        run_burst("hold_trail", 1'b1, -1);
        burst_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hF5};
        run_burst("chained5", 1'b0, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
